// File: rtl/fmap_buf_arb.sv
// Frame-level write arbiter/sequencer for the split-bank feature-map buffer.
// Optional idle-abort watchdog is built only when FRAME_TIMEOUT_EN is defined.
//
// state | meaning
// CLEAR | pulse buf_reset for one cycle, then re-arbitrate
// IDLE  | wait for a producer, grant one (round-robin on contention)
// FILL  | accept SIZE words from the owner, forwarded to the buffer
// HOLD  | full frame held until consumer_done
module fmap_buf_arb #(
    parameter int DATA_WIDTH = 16,
    parameter int SIZE       = 65536,
    parameter int HALF_SIZE  = 32768,
    parameter int TIMEOUT    = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              req_valid,
    input  logic [DATA_WIDTH-1:0]   req_data0,
    input  logic [DATA_WIDTH-1:0]   req_data1,
    output logic [1:0]              req_ready,
    output logic                    buf_write,
    output logic [DATA_WIDTH-1:0]   buf_data,
    output logic                    buf_reset,
    output logic                    owner,
    output logic                    bank,
    output logic [$clog2(SIZE):0]   wcount,
    output logic                    frame_ready,
    input  logic                    consumer_done,
    output logic                    err_timeout
);

    localparam int CW = $clog2(SIZE) + 1;
    localparam logic [CW-1:0] SIZE_W = CW'(SIZE);
    localparam logic [CW-1:0] HALF_W = CW'(HALF_SIZE);

    if (HALF_SIZE * 2 != SIZE || TIMEOUT < 1) begin : g_bad_param
        $error("fmap_buf_arb: HALF_SIZE must be SIZE/2 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_HOLD, ST_CLEAR} state_t;

    state_t                  state_q, state_d;
    logic                    owner_q, owner_d;
    logic                    rr_q, rr_d;
    logic                    buf_write_q, buf_write_d;
    logic [DATA_WIDTH-1:0]   buf_data_q, buf_data_d;
    logic [CW-1:0]           wcount_q, wcount_d;
    logic                    accept;
    logic                    timeout_hit;

    assign accept = (state_q == ST_FILL) && req_valid[owner_q];

`ifdef FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] idle_cnt_q, idle_cnt_d;

    // Down-counter reloaded on grant and every accept; fires on the TIMEOUT-th idle cycle.
    always_comb begin
        idle_cnt_d  = idle_cnt_q;
        timeout_hit = 1'b0;
        if (state_q == ST_IDLE || accept) begin
            idle_cnt_d = TW'(TIMEOUT - 1);
        end else if (state_q == ST_FILL) begin
            if (idle_cnt_q == '0) begin
                timeout_hit = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idle_cnt_q <= TW'(TIMEOUT - 1);
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        wcount_d    = wcount_q;
        buf_write_d = 1'b0;
        buf_data_d  = buf_data_q;
        req_ready   = 2'b00;
        case (state_q)
            ST_CLEAR: begin
                wcount_d = '0;
                state_d  = ST_IDLE;
            end
            ST_IDLE: begin
                if (req_valid != 2'b00) begin
                    owner_d  = (req_valid == 2'b11) ? rr_q : req_valid[1];
                    wcount_d = '0;
                    state_d  = ST_FILL;
                end
            end
            ST_FILL: begin
                req_ready = owner_q ? 2'b10 : 2'b01;
                if (accept) begin
                    buf_write_d = 1'b1;
                    buf_data_d  = owner_q ? req_data1 : req_data0;
                    wcount_d    = (wcount_q == SIZE_W) ? wcount_q : wcount_q + 1'b1;
                    if (wcount_q == SIZE_W - 1'b1) begin
                        state_d = ST_HOLD;
                    end
                end else if (timeout_hit) begin
                    rr_d    = ~owner_q;
                    state_d = ST_CLEAR;
                end
            end
            ST_HOLD: begin
                if (consumer_done) begin
                    rr_d    = ~owner_q;
                    state_d = ST_CLEAR;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_CLEAR;
            owner_q     <= 1'b0;
            rr_q        <= 1'b0;
            buf_write_q <= 1'b0;
            buf_data_q  <= '0;
            wcount_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            buf_write_q <= buf_write_d;
            buf_data_q  <= buf_data_d;
            wcount_q    <= wcount_d;
        end
    end

    assign buf_write   = buf_write_q;
    assign buf_data    = buf_data_q;
    assign buf_reset   = (state_q == ST_CLEAR);
    assign frame_ready = (state_q == ST_HOLD);
    assign owner       = owner_q;
    assign wcount      = wcount_q;
    assign bank        = (wcount_q >= HALF_W);
    assign err_timeout = timeout_hit;

endmodule

// File: tb/tb_fmap_buf_arb.sv
// Directed self-checking bench for fmap_buf_arb with SIZE=8, HALF_SIZE=4, TIMEOUT=5.
// The idle-abort scenario runs only when FRAME_TIMEOUT_EN is defined.
module tb_fmap_buf_arb;
    localparam int DW = 16;
    localparam int SZ = 8;
    localparam int HS = 4;
    localparam int TO = 5;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [1:0]      req_valid = 2'b00;
    logic [DW-1:0]   req_data0 = '0;
    logic [DW-1:0]   req_data1 = '0;
    logic            consumer_done = 1'b0;
    logic [1:0]      req_ready;
    logic            buf_write;
    logic [DW-1:0]   buf_data;
    logic            buf_reset;
    logic            owner;
    logic            bank;
    logic [3:0]      wcount;
    logic            frame_ready;
    logic            err_timeout;

    int n_chk = 0;
    int n_fail = 0;
    int n_overlap = 0;
    logic [DW-1:0] wr_q[$];

    fmap_buf_arb #(.DATA_WIDTH(DW), .SIZE(SZ), .HALF_SIZE(HS), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid),
        .req_data0(req_data0), .req_data1(req_data1), .req_ready(req_ready),
        .buf_write(buf_write), .buf_data(buf_data), .buf_reset(buf_reset),
        .owner(owner), .bank(bank), .wcount(wcount), .frame_ready(frame_ready),
        .consumer_done(consumer_done), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Write log sampled at the edge, i.e. the value held through the previous cycle.
    always @(posedge clk) begin
        if (buf_write === 1'b1) wr_q.push_back(buf_data);
        if (buf_write === 1'b1 && buf_reset === 1'b1) n_overlap++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_writes(input int n, input logic [DW-1:0] base);
        check_eq("wr_count", wr_q.size(), n);
        for (int i = 0; i < wr_q.size() && i < n; i++)
            check_eq("wr_data", wr_q[i], base + DW'(i) + 1'b1);
        wr_q.delete();
    endtask

    // Called at a negedge while HOLD; leaves the DUT in IDLE at a negedge.
    task automatic release_frame();
        consumer_done = 1'b1;
        @(negedge clk);
        consumer_done = 1'b0;
        check_eq("rel_buf_reset", buf_reset, 1'b1);
        check_eq("rel_frame_ready", frame_ready, 1'b0);
        check_eq("rel_buf_write", buf_write, 1'b0);
        @(negedge clk);
        check_eq("idle_buf_reset", buf_reset, 1'b0);
        check_eq("idle_wcount", wcount, 0);
    endtask

    // Called at a negedge in IDLE; runs one full frame from producer p.
    task automatic run_frame(input logic [1:0] vmask, input int p, input logic [DW-1:0] base,
                             input bit stall, input int exp_cycles);
        int k;
        int cyc;
        logic v;
        req_valid = vmask;
        @(negedge clk);
        check_eq("grant_owner", owner, p);
        k = 0;
        cyc = 0;
        while (k < SZ && cyc < 4 * SZ) begin
            check_eq("fill_ready", req_ready, (p == 1) ? 2'b10 : 2'b01);
            check_eq("fill_wcount", wcount, k);
            check_eq("fill_bank", bank, (k >= HS));
            v = stall ? cyc[0] : 1'b1;
            req_valid = vmask;
            req_valid[p] = v;
            if (p == 0) begin
                req_data0 = base + DW'(k) + 1'b1;
                req_data1 = 16'hBEEF;
            end else begin
                req_data1 = base + DW'(k) + 1'b1;
                req_data0 = 16'hBEEF;
            end
            @(negedge clk);
            if (v) k++;
            cyc++;
        end
        req_valid = 2'b00;
        check_eq("fill_cycles", cyc, exp_cycles);
        check_eq("hold_frame_ready", frame_ready, 1'b1);
        check_eq("hold_ready", req_ready, 2'b00);
        check_eq("hold_wcount", wcount, SZ);
        check_eq("hold_bank", bank, 1'b1);
        @(negedge clk);
        check_eq("hold2_frame_ready", frame_ready, 1'b1);
        check_eq("hold2_buf_write", buf_write, 1'b0);
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk);
        check_eq("rst_buf_reset", buf_reset, 1'b1);
        check_eq("rst_buf_write", buf_write, 1'b0);
        check_eq("rst_req_ready", req_ready, 2'b00);
        check_eq("rst_frame_ready", frame_ready, 1'b0);
        check_eq("rst_wcount", wcount, 0);
        check_eq("rst_owner", owner, 1'b0);
        check_eq("rst_err_timeout", err_timeout, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rel_idle_buf_reset", buf_reset, 1'b0);
        check_eq("rel_idle_ready", req_ready, 2'b00);
        check_eq("rel_idle_wcount", wcount, 0);

        // Contention: 0, then 1, then 0 again with stalled owner.
        run_frame(2'b11, 0, 16'h0000, 1'b0, 8);
        release_frame();
        check_writes(SZ, 16'h0000);
        run_frame(2'b11, 1, 16'h0010, 1'b0, 8);
        release_frame();
        check_writes(SZ, 16'h0010);
        run_frame(2'b11, 0, 16'h0020, 1'b1, 16);
        release_frame();
        check_writes(SZ, 16'h0020);
        // Single producer 0 wins even though producer 1 holds priority.
        run_frame(2'b01, 0, 16'h0030, 1'b0, 8);
        release_frame();
        check_writes(SZ, 16'h0030);

        // consumer_done during FILL is ignored; reset at wcount=5 aborts the frame.
        req_valid = 2'b10;
        @(negedge clk);
        check_eq("b_owner", owner, 1'b1);
        k = 0;
        while (k < 3) begin
            req_data1 = 16'h0040 + DW'(k) + 1'b1;
            consumer_done = (k == 2);
            @(negedge clk);
            k++;
        end
        consumer_done = 1'b0;
        check_eq("b_done_ignored_ready", req_ready, 2'b10);
        check_eq("b_done_ignored_frame", frame_ready, 1'b0);
`ifndef FRAME_TIMEOUT_EN
        req_valid = 2'b00;
        repeat (2 * TO) begin
            @(negedge clk);
            check_eq("b_no_timeout", err_timeout, 1'b0);
        end
        check_eq("b_stall_ready", req_ready, 2'b10);
        check_eq("b_stall_wcount", wcount, 3);
        req_valid = 2'b10;
`endif
        while (k < 5) begin
            req_data1 = 16'h0040 + DW'(k) + 1'b1;
            @(negedge clk);
            k++;
        end
        check_eq("b_wcount5", wcount, 5);
        reset = 1'b0;
        req_valid = 2'b00;
        @(negedge clk);
        check_eq("b_rst_buf_reset", buf_reset, 1'b1);
        check_eq("b_rst_wcount", wcount, 0);
        check_eq("b_rst_buf_write", buf_write, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("b_idle_buf_reset", buf_reset, 1'b0);
        repeat (3) @(negedge clk);
        check_eq("b_idle_ready", req_ready, 2'b00);
        check_writes(5, 16'h0040);

`ifdef FRAME_TIMEOUT_EN
        req_valid = 2'b01;
        @(negedge clk);
        check_eq("t_owner", owner, 1'b0);
        for (int i = 0; i < 3; i++) begin
            req_data0 = 16'h0050 + DW'(i) + 1'b1;
            @(negedge clk);
        end
        req_valid = 2'b00;
        for (int i = 1; i <= TO; i++) begin
            #1;
            check_eq("t_err_timeout", err_timeout, (i == TO));
            check_eq("t_frame_ready", frame_ready, 1'b0);
            @(negedge clk);
        end
        check_eq("t_buf_reset", buf_reset, 1'b1);
        check_eq("t_err_after", err_timeout, 1'b0);
        check_eq("t_frame_ready_clr", frame_ready, 1'b0);
        @(negedge clk);
        req_valid = 2'b11;
        @(negedge clk);
        check_eq("t_next_owner", owner, 1'b1);
        req_valid = 2'b00;
        @(negedge clk);
        check_writes(3, 16'h0050);
`endif

        check_eq("write_reset_overlap", n_overlap, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
